// File: rtl/latch_wr_sched.sv
// Round-robin write scheduler for a level-sensitive latch bank: setup, enable pulse, hold.
// Optional clear sequence enabled by defining LATCH_WR_SCHED_CLR_EN (adds clr_req port).
module latch_wr_sched #(
  parameter int NREQ      = 4,
  parameter int DW        = 8,
  parameter int SETUP_CYC = 1,
  parameter int EN_CYC    = 1,
  parameter int HOLD_CYC  = 1
) (
  input  logic               clk,
  input  logic               rstn,
`ifdef LATCH_WR_SCHED_CLR_EN
  input  logic               clr_req,
`endif
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*DW-1:0] wdata,
  output logic [NREQ-1:0]    gnt,
  output logic [NREQ-1:0]    done,
  output logic [DW-1:0]      lat_d,
  output logic               lat_en,
  output logic               lat_rstn,
  output logic               busy
);

  localparam int IW   = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CMAX = (SETUP_CYC > EN_CYC) ?
                        ((SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC) :
                        ((EN_CYC > HOLD_CYC) ? EN_CYC : HOLD_CYC);
  localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;

  localparam logic [CW-1:0] LD_SETUP = CW'(SETUP_CYC - 1);
  localparam logic [CW-1:0] LD_EN    = CW'(EN_CYC - 1);
  localparam logic [CW-1:0] LD_HOLD  = CW'(HOLD_CYC - 1);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    ENABLE,
    HOLD,
    DONE
`ifdef LATCH_WR_SCHED_CLR_EN
    , CLEAR
`endif
  } state_t;

  state_t          state, state_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic [IW-1:0]   ptr, ptr_n;
  logic [IW-1:0]   win, win_n;
  logic [NREQ-1:0] gnt_n, done_n;
  logic [DW-1:0]   lat_d_n;
  logic            lat_en_n, lat_rstn_n, busy_n;

  logic            pick_vld;
  logic [IW-1:0]   pick;

  // First requester at or after the rr pointer, wrapping past NREQ-1.
  always_comb begin
    int j;
    j        = 0;
    pick_vld = 1'b0;
    pick     = '0;
    for (int i = 0; i < NREQ; i++) begin
      j = int'(ptr) + i;
      if (j >= NREQ) j = j - NREQ;
      if (!pick_vld && req[j]) begin
        pick_vld = 1'b1;
        pick     = IW'(j);
      end
    end
  end

  // NOTE: every variable driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    ptr_n      = ptr;
    win_n      = win;
    gnt_n      = gnt;
    done_n     = '0;
    lat_d_n    = lat_d;
    lat_en_n   = 1'b0;
    lat_rstn_n = 1'b1;

    unique case (state)
      IDLE: begin
`ifdef LATCH_WR_SCHED_CLR_EN
        if (clr_req) begin
          state_n    = CLEAR;
          cnt_n      = LD_EN;
          gnt_n      = '0;
          lat_rstn_n = 1'b0;
        end else
`endif
        if (pick_vld) begin
          state_n = SETUP;
          cnt_n   = LD_SETUP;
          win_n   = pick;
          gnt_n   = NREQ'(1) << pick;
          lat_d_n = wdata[int'(pick)*DW +: DW];
        end
      end
      SETUP: begin
        if (cnt == '0) begin
          state_n  = ENABLE;
          cnt_n    = LD_EN;
          lat_en_n = 1'b1;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      ENABLE: begin
        if (cnt == '0) begin
          state_n = HOLD;
          cnt_n   = LD_HOLD;
        end else begin
          cnt_n    = cnt - 1'b1;
          lat_en_n = 1'b1;
        end
      end
      HOLD: begin
        if (cnt == '0) begin
          state_n     = DONE;
          done_n[win] = 1'b1;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      DONE: begin
        state_n = IDLE;
        gnt_n   = '0;
        ptr_n   = (win == IW'(NREQ - 1)) ? '0 : win + 1'b1;
      end
`ifdef LATCH_WR_SCHED_CLR_EN
      CLEAR: begin
        if (cnt == '0) begin
          state_n = IDLE;
        end else begin
          cnt_n      = cnt - 1'b1;
          lat_rstn_n = 1'b0;
        end
      end
`endif
      default: begin
        state_n = IDLE;
        gnt_n   = '0;
      end
    endcase

    busy_n = (state_n != IDLE);
  end

  // NOTE: registered state and outputs use non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state    <= IDLE;
      cnt      <= '0;
      ptr      <= '0;
      win      <= '0;
      gnt      <= '0;
      done     <= '0;
      lat_d    <= '0;
      lat_en   <= 1'b0;
      lat_rstn <= 1'b1;
      busy     <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      ptr      <= ptr_n;
      win      <= win_n;
      gnt      <= gnt_n;
      done     <= done_n;
      lat_d    <= lat_d_n;
      lat_en   <= lat_en_n;
      lat_rstn <= lat_rstn_n;
      busy     <= busy_n;
    end
  end

endmodule

// File: tb/tb_latch_wr_sched.sv
// Self-checking bench for latch_wr_sched: directed scenarios plus randomized traffic
// against a transaction-level timeline model (grant -> setup/enable/hold -> done).
module tb_latch_wr_sched;

  localparam int NREQ = 4;
  localparam int DW   = 8;
  localparam int S = 1, E = 1, H = 1;
  localparam int L = S + E + H;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Main instance, default timing
  logic [NREQ-1:0]    req;
  logic [DW-1:0]      wd [NREQ];
  logic [NREQ*DW-1:0] wdata;
  logic [NREQ-1:0]    gnt, done;
  logic [DW-1:0]      lat_d;
  logic               lat_en, lat_rstn, busy;
  logic               clr_req;

  assign wdata = {wd[3], wd[2], wd[1], wd[0]};

  latch_wr_sched #(.NREQ(NREQ), .DW(DW), .SETUP_CYC(S), .EN_CYC(E), .HOLD_CYC(H)) dut (
    .clk(clk), .rstn(rstn),
`ifdef LATCH_WR_SCHED_CLR_EN
    .clr_req(clr_req),
`endif
    .req(req), .wdata(wdata), .gnt(gnt), .done(done),
    .lat_d(lat_d), .lat_en(lat_en), .lat_rstn(lat_rstn), .busy(busy)
  );

  // Second instance with stretched setup/enable/hold
  logic [NREQ-1:0]    req2;
  logic [NREQ*DW-1:0] wdata2;
  logic [NREQ-1:0]    gnt2, done2;
  logic [DW-1:0]      lat_d2;
  logic               lat_en2, lat_rstn2, busy2;

  latch_wr_sched #(.NREQ(NREQ), .DW(DW), .SETUP_CYC(2), .EN_CYC(3), .HOLD_CYC(2)) dut2 (
    .clk(clk), .rstn(rstn),
`ifdef LATCH_WR_SCHED_CLR_EN
    .clr_req(1'b0),
`endif
    .req(req2), .wdata(wdata2), .gnt(gnt2), .done(done2),
    .lat_d(lat_d2), .lat_en(lat_en2), .lat_rstn(lat_rstn2), .busy(busy2)
  );

  int checks   = 0;
  int failures = 0;

  int m_ptr;          // model round-robin pointer
  bit prev_pending;   // a request was still pending when the last transfer completed
  int last_g;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    req  = '0;
    repeat (2) @(negedge clk);
    check("rst_gnt", 32'(gnt), 0);
    check("rst_done", 32'(done), 0);
    check("rst_lat_d", 32'(lat_d), 0);
    check("rst_lat_en", 32'(lat_en), 0);
    check("rst_lat_rstn", 32'(lat_rstn), 1);
    check("rst_busy", 32'(busy), 0);
    rstn = 1'b1;
    m_ptr = 0;
    prev_pending = 1'b0;
  endtask

  // One transfer on the main instance, checked cycle by cycle from the grant edge.
  task automatic run_txn(input bit keep, input bit rnd, output int w, output int g_cyc);
    logic [NREQ-1:0] exp_oh;
    logic [DW-1:0]   exp_d;
    int t;
    w = -1;
    g_cyc = 0;
    for (int i = 0; i < NREQ; i++) begin
      int idx;
      idx = (m_ptr + i) % NREQ;
      if (w < 0 && req[idx]) w = idx;
    end
    if (w < 0) begin
      check("model_no_req", 0, 1);
      return;
    end
    exp_oh = NREQ'(1) << w;
    exp_d  = wd[w];
    t = 0;
    @(negedge clk);
    while (gnt == '0 && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (gnt == '0) begin
      check("gnt_timeout", 0, 1);
      return;
    end
    g_cyc = cyc;
    if (prev_pending) check("grant_gap", 32'(cyc - last_g), L + 2);
    last_g = cyc;
    for (int off = 0; off <= L + 1; off++) begin
      if (off > 0) @(negedge clk);
      check("gnt",    32'(gnt),    (off <= L) ? 32'(exp_oh) : 0);
      check("done",   32'(done),   (off == L) ? 32'(exp_oh) : 0);
      check("lat_en", 32'(lat_en), (off >= S && off < S + E) ? 1 : 0);
      check("busy",   32'(busy),   (off <= L) ? 1 : 0);
      check("lat_d",  32'(lat_d),  32'(exp_d));
      if (rnd) wd[$urandom_range(0, NREQ-1)] = DW'($urandom);
      if (off == L) begin
        if (!keep) req[w] = 1'b0;
        if (rnd) req = req | NREQ'($urandom_range(0, 15));
        prev_pending = (req != '0);
      end
    end
    m_ptr = (w + 1) % NREQ;
  endtask

  initial begin
    int w, g, t, en_cnt;
    logic [DW-1:0] d2;
    rstn = 1'b0; req = '0; clr_req = 1'b0; req2 = '0; wdata2 = '0;
    last_g = 0;
    for (int i = 0; i < NREQ; i++) wd[i] = DW'($urandom);

    // Reset and a single write from requester 2
    do_reset();
    wd[2] = 8'hA5;
    req = 4'b0100;
    run_txn(1'b0, 1'b0, w, g);
    check("single_winner", 32'(w), 2);
    check("lat_d_held_idle", 32'(lat_d), 32'h A5);

    // Reset while lat_en is high aborts the transfer
    wd[0] = DW'($urandom);
    req = 4'b0001;
    t = 0;
    @(negedge clk);
    while (!lat_en && t < 20) begin
      @(negedge clk);
      t++;
    end
    check("reach_enable", 32'(lat_en), 1);
    rstn = 1'b0;
    req  = '0;
    @(negedge clk);
    check("abort_lat_en", 32'(lat_en), 0);
    check("abort_gnt", 32'(gnt), 0);
    check("abort_busy", 32'(busy), 0);
    rstn = 1'b1;
    m_ptr = 0;
    prev_pending = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("abort_no_done", 32'(done), 0);
    end
    req = 4'b0010;
    run_txn(1'b0, 1'b0, w, g);
    check("post_abort_winner", 32'(w), 1);

    // Round-robin with all four requesting
    do_reset();
    for (int i = 0; i < NREQ; i++) wd[i] = DW'($urandom);
    req = 4'b1111;
    for (int i = 0; i < NREQ; i++) begin
      run_txn(1'b0, 1'b0, w, g);
      check("rr_order", 32'(w), 32'(i));
    end

    // Wrap and re-request: 0,3,0,3 spaced 5 cycles apart
    req = 4'b1001;
    for (int i = 0; i < 4; i++) begin
      run_txn(1'b1, 1'b0, w, g);
      check("wrap_order", 32'(w), (i % 2 == 0) ? 0 : 3);
    end
    req = '0;
    prev_pending = 1'b0;

    // Randomized traffic with wdata churning after each grant
    for (int n = 0; n < 24; n++) begin
      if (req == '0) begin
        req = NREQ'($urandom_range(1, 15));
        prev_pending = 1'b0;
      end
      run_txn(1'b0, 1'b1, w, g);
    end
    req = '0;
    prev_pending = 1'b0;
    repeat (2) @(negedge clk);

    // Data stability with SETUP=2, EN=3, HOLD=2
    wdata2 = NREQ*DW'($urandom);
    d2 = wdata2[DW-1:0];
    req2 = 4'b0001;
    t = 0;
    @(negedge clk);
    while (gnt2 == '0 && t < 20) begin
      @(negedge clk);
      t++;
    end
    check("stab_gnt", 32'(gnt2), 1);
    en_cnt = 0;
    for (int off = 0; off <= 8; off++) begin
      if (off > 0) @(negedge clk);
      if (off <= 6) check("stab_lat_d", 32'(lat_d2), 32'(d2));
      check("stab_done", 32'(done2), (off == 7) ? 1 : 0);
      if (lat_en2) en_cnt++;
      wdata2[DW-1:0] = ~wdata2[DW-1:0];
      if (off == 7) req2 = '0;
    end
    check("stab_en_cycles", 32'(en_cnt), 3);
    check("stab_idle_busy", 32'(busy2), 0);

`ifdef LATCH_WR_SCHED_CLR_EN
    // Clear has priority over a simultaneous request
    clr_req = 1'b1;
    req = 4'b0001;
    t = cyc;
    @(negedge clk);
    check("clr_lat_rstn", 32'(lat_rstn), 0);
    check("clr_lat_en", 32'(lat_en), 0);
    check("clr_gnt", 32'(gnt), 0);
    check("clr_busy", 32'(busy), 1);
    clr_req = 1'b0;
    @(negedge clk);
    check("clr_release", 32'(lat_rstn), 1);
    check("clr_idle_gnt", 32'(gnt), 0);
    run_txn(1'b0, 1'b0, w, g);
    check("clr_winner", 32'(w), 0);
    check("clr_grant_delay", 32'(g - t), 3);
    req = '0;
`endif

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/latch_wr_sched.md
Name: latch_wr_sched

Overview:
- Arbitrates NREQ requesters writing a shared level-sensitive D-latch bank (DW bits wide).
- Sequences each write as data setup, then enable pulse, then data hold, so latch d is never changing while en is high.
- Sits between the requesters and the latch bank; owns the bank's d and en pins.
- Round-robin arbitration; one transfer in flight at a time.

Parameters:
- NREQ, 4, number of requesters (2..16)
- DW, 8, latch data width
- SETUP_CYC, 1, cycles lat_d is stable before lat_en rises (>=1)
- EN_CYC, 1, cycles lat_en is high (>=1)
- HOLD_CYC, 1, cycles lat_d is held after lat_en falls (>=1)

Ports:
- clk  in  1  clock, rising edge
- rstn  in  1  reset, synchronous, active-low
- req  in  NREQ  write request per requester; held high until that requester's done
- wdata  in  NREQ*DW  per-requester write data; slice i = wdata[i*DW +: DW]
- gnt  out  NREQ  one-hot grant, high from grant through DONE cycle
- done  out  NREQ  one-cycle completion pulse to the granted requester
- lat_d  out  DW  data to latch bank d inputs
- lat_en  out  1  latch bank enable, registered, glitch-free
- lat_rstn  out  1  latch bank active-low reset (see optional feature)
- busy  out  1  high in every state except IDLE

Behaviour:
- Reset (rstn=0 at a clk edge): state IDLE, gnt=0, done=0, lat_d=0, lat_en=0, lat_rstn=1, busy=0, rr pointer=0.
- Reset mid-transfer aborts it: lat_en low from the next edge, no done pulse.
- All outputs are registered.
- States: IDLE, SETUP, ENABLE, HOLD, DONE. One down-counter is reloaded on each state entry.
- IDLE, req!=0:
  - Pick the first set req at or after the rr pointer, wrapping NREQ-1 to 0.
  - Next edge: gnt=onehot(winner), lat_d=wdata slice of winner (captured once), go to SETUP.
- SETUP lasts SETUP_CYC cycles, then ENABLE.
- ENABLE lasts EN_CYC cycles with lat_en=1, then HOLD. lat_en=0 in all other states.
- HOLD lasts HOLD_CYC cycles, then DONE.
- DONE lasts exactly 1 cycle:
  - done[winner]=1, gnt still high.
  - Next edge: gnt=0, done=0, rr pointer = winner+1 mod NREQ, go to IDLE.
- lat_d is held from the grant edge until the next grant. It is not cleared in IDLE.
- Changes to wdata or req after the grant are ignored. If req drops mid-transfer, the transfer still completes and done still pulses.
- Minimum edge-to-edge spacing between grants is SETUP_CYC+EN_CYC+HOLD_CYC+2 cycles.
- A requester holding req through its done cycle is re-eligible, but the rr pointer has already moved past it.
- With defaults, req sampled at edge k gives:
  - gnt at k+1
  - lat_en high for the cycle after edge k+2
  - done for the cycle after edge k+4
  - IDLE again at k+5

Optional Feature:
- Macro LATCH_WR_SCHED_CLR_EN adds an input port clr_req (1 bit, level).
- With the macro defined:
  - In IDLE, clr_req has priority over req.
  - Next edge enters state CLEAR for EN_CYC cycles: lat_rstn=0, lat_en=0, gnt=0, busy=1.
  - Then 1 cycle in IDLE before the next arbitration. The rr pointer is unchanged and there is no done pulse.
  - clr_req is sampled only in IDLE.
- Without the macro: no clr_req port, no CLEAR state, lat_rstn tied to 1.

Test Plan:
- Reset then single write, defaults:
  - Stimulus: req=4'b0100, wdata[23:16]=8'hA5.
  - Required: gnt=4'b0100 at k+1; lat_d=8'hA5 from k+1; lat_en=1 for exactly 1 cycle (after edge k+2); done[2]=1 for 1 cycle after edge k+4.
- Round-robin, all requesting:
  - Stimulus: req=4'b1111 held, each requester dropping req after its done.
  - Required: grant order 0,1,2,3; lat_d equals each requester's wdata slice during its lat_en pulse.
- Data stability:
  - Stimulus: SETUP_CYC=2, EN_CYC=3, HOLD_CYC=2; wdata[0] toggles every cycle after the grant.
  - Required: lat_d is constant over the 7 cycles from grant to DONE; lat_en is high for exactly 3 cycles.
- Reset during ENABLE:
  - Stimulus: rstn=0 while lat_en=1.
  - Required: next edge gives lat_en=0, gnt=0, no done pulse, rr pointer=0; the next req=4'b0010 is granted to requester 1.
- Wrap and re-request:
  - Stimulus: req=4'b1001 held continuously.
  - Required: grants alternate 0,3,0,3 (pointer wraps 3 to 0); grants are separated by 5 cycles with defaults.
- Clear priority (LATCH_WR_SCHED_CLR_EN defined):
  - Stimulus: clr_req=1 and req=4'b0001 together in IDLE.
  - Required: lat_rstn=0 for 1 cycle, lat_en stays 0, then requester 0 is granted 2 edges later.
